// File: rtl/idecode_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : idecode_stage_if
// Brief    : IF/ID, writeback and ID/EX signal bundle for the decode stage.
// Revision : 1.0
// ============================================================================
interface idecode_stage_if #(
   parameter int PARAM_PC_BITS = 10
);
   logic [31:0]              ip_instruction;
   logic [PARAM_PC_BITS-1:0] ip_PC_plus_4;
   logic                     ip_flush;
   logic                     ip_wb_reg_write;
   logic [4:0]               ip_wb_write_reg;
   logic [31:0]              ip_wb_write_data;

   logic                     op_stall;
   logic [31:0]              op_read_data_1;
   logic [31:0]              op_read_data_2;
   logic [31:0]              op_sign_extend;
   logic [PARAM_PC_BITS-1:0] op_PC_plus_4;
   logic [4:0]               op_rt;
   logic [4:0]               op_rd;
   logic [5:0]               op_funct;
   logic [1:0]               op_alu_op;
   logic                     op_reg_dst;
   logic                     op_alu_src;
   logic                     op_mem_to_reg;
   logic                     op_reg_write;
   logic                     op_mem_read;
   logic                     op_mem_write;
   logic                     op_branch;

   modport master (
      output ip_instruction, ip_PC_plus_4, ip_flush,
             ip_wb_reg_write, ip_wb_write_reg, ip_wb_write_data,
      input  op_stall, op_read_data_1, op_read_data_2, op_sign_extend,
             op_PC_plus_4, op_rt, op_rd, op_funct, op_alu_op,
             op_reg_dst, op_alu_src, op_mem_to_reg, op_reg_write,
             op_mem_read, op_mem_write, op_branch
   );

   modport slave (
      input  ip_instruction, ip_PC_plus_4, ip_flush,
             ip_wb_reg_write, ip_wb_write_reg, ip_wb_write_data,
      output op_stall, op_read_data_1, op_read_data_2, op_sign_extend,
             op_PC_plus_4, op_rt, op_rd, op_funct, op_alu_op,
             op_reg_dst, op_alu_src, op_mem_to_reg, op_reg_write,
             op_mem_read, op_mem_write, op_branch
   );
endinterface
`default_nettype wire

// File: rtl/idecode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : idecode_stage
// Brief    : MIPS decode stage: register file, main control, load-use stall,
//            ID/EX register. IDECODE_WB_BYPASS_EN enables write-before-read.
// Revision : 1.0
// ============================================================================
module idecode_stage #(
   parameter int PARAM_NUM_REGS = 32,
   parameter int PARAM_PC_BITS  = 10
) (
   input  logic           clock,
   input  logic           reset,
   idecode_stage_if.slave bus
);
   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;

   logic [31:0] regs [PARAM_NUM_REGS];

   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd;
   logic        unused_shamt;

   assign opcode       = bus.ip_instruction[31:26];
   assign rs           = bus.ip_instruction[25:21];
   assign rt           = bus.ip_instruction[20:16];
   assign rd           = bus.ip_instruction[15:11];
   assign unused_shamt = ^bus.ip_instruction[10:6];

   logic       reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
   logic [1:0] alu_op;

   // An all-zero word is the canonical nop even though its opcode is R-type.
   always_comb begin
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      branch     = 1'b0;
      alu_op     = 2'b00;
      if (bus.ip_instruction != 32'd0) begin
         case (opcode)
            OPC_RTYPE: begin
               reg_dst   = 1'b1;
               reg_write = 1'b1;
               alu_op    = 2'b10;
            end
            OPC_LW: begin
               alu_src    = 1'b1;
               mem_to_reg = 1'b1;
               reg_write  = 1'b1;
               mem_read   = 1'b1;
            end
            OPC_SW: begin
               alu_src   = 1'b1;
               mem_write = 1'b1;
            end
            OPC_BEQ: begin
               branch = 1'b1;
               alu_op = 2'b01;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PARAM_NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.ip_wb_reg_write && (bus.ip_wb_write_reg != 5'd0)) begin
         regs[bus.ip_wb_write_reg] <= bus.ip_wb_write_data;
      end
   end

   logic [31:0] rf_data_1, rf_data_2, read_data_1, read_data_2;

   assign rf_data_1 = (rs == 5'd0) ? 32'd0 : regs[rs];
   assign rf_data_2 = (rt == 5'd0) ? 32'd0 : regs[rt];

`ifdef IDECODE_WB_BYPASS_EN
   logic wb_active;
   assign wb_active = bus.ip_wb_reg_write && (bus.ip_wb_write_reg != 5'd0);

   always_comb begin
      read_data_1 = rf_data_1;
      read_data_2 = rf_data_2;
      if (wb_active && (bus.ip_wb_write_reg == rs)) read_data_1 = bus.ip_wb_write_data;
      if (wb_active && (bus.ip_wb_write_reg == rt)) read_data_2 = bus.ip_wb_write_data;
   end
`else
   assign read_data_1 = rf_data_1;
   assign read_data_2 = rf_data_2;
`endif

   logic [31:0]              ex_read_data_1, ex_read_data_2, ex_sign_extend;
   logic [PARAM_PC_BITS-1:0] ex_pc_plus_4;
   logic [4:0]               ex_rt, ex_rd;
   logic [5:0]               ex_funct;
   logic [1:0]               ex_alu_op;
   logic                     ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
   logic                     ex_mem_read, ex_mem_write, ex_branch;

   // Only instructions that actually source rt may match the load on rt.
   logic rt_is_source, hazard;
   assign rt_is_source = (opcode == OPC_RTYPE) || (opcode == OPC_SW) || (opcode == OPC_BEQ);
   assign hazard       = ex_mem_read && (ex_rt != 5'd0) &&
                         ((ex_rt == rs) || ((ex_rt == rt) && rt_is_source));
   assign bus.op_stall = hazard && !bus.ip_flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset || bus.ip_flush || hazard) begin
         ex_read_data_1 <= '0;
         ex_read_data_2 <= '0;
         ex_sign_extend <= '0;
         ex_pc_plus_4   <= '0;
         ex_rt          <= '0;
         ex_rd          <= '0;
         ex_funct       <= '0;
         ex_alu_op      <= '0;
         ex_reg_dst     <= 1'b0;
         ex_alu_src     <= 1'b0;
         ex_mem_to_reg  <= 1'b0;
         ex_reg_write   <= 1'b0;
         ex_mem_read    <= 1'b0;
         ex_mem_write   <= 1'b0;
         ex_branch      <= 1'b0;
      end else begin
         ex_read_data_1 <= read_data_1;
         ex_read_data_2 <= read_data_2;
         ex_sign_extend <= {{16{bus.ip_instruction[15]}}, bus.ip_instruction[15:0]};
         ex_pc_plus_4   <= bus.ip_PC_plus_4;
         ex_rt          <= rt;
         ex_rd          <= rd;
         ex_funct       <= bus.ip_instruction[5:0];
         ex_alu_op      <= alu_op;
         ex_reg_dst     <= reg_dst;
         ex_alu_src     <= alu_src;
         ex_mem_to_reg  <= mem_to_reg;
         ex_reg_write   <= reg_write;
         ex_mem_read    <= mem_read;
         ex_mem_write   <= mem_write;
         ex_branch      <= branch;
      end
   end

   assign bus.op_read_data_1 = ex_read_data_1;
   assign bus.op_read_data_2 = ex_read_data_2;
   assign bus.op_sign_extend = ex_sign_extend;
   assign bus.op_PC_plus_4   = ex_pc_plus_4;
   assign bus.op_rt          = ex_rt;
   assign bus.op_rd          = ex_rd;
   assign bus.op_funct       = ex_funct;
   assign bus.op_alu_op      = ex_alu_op;
   assign bus.op_reg_dst     = ex_reg_dst;
   assign bus.op_alu_src     = ex_alu_src;
   assign bus.op_mem_to_reg  = ex_mem_to_reg;
   assign bus.op_reg_write   = ex_reg_write;
   assign bus.op_mem_read    = ex_mem_read;
   assign bus.op_mem_write   = ex_mem_write;
   assign bus.op_branch      = ex_branch;
endmodule
`default_nettype wire

// File: tb/tb_idecode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_idecode_stage
// Brief    : Vector table, corner sequences and random run against a model.
// Revision : 1.0
// ============================================================================
module tb_idecode_stage;
   localparam int PC_BITS = 10;

   // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}
   localparam logic [8:0] CTL_NOP = 9'b000000000;
   localparam logic [8:0] CTL_R   = 9'b100100010;
   localparam logic [8:0] CTL_LW  = 9'b011110000;
   localparam logic [8:0] CTL_SW  = 9'b010001000;
   localparam logic [8:0] CTL_BEQ = 9'b000000101;

`ifdef IDECODE_WB_BYPASS_EN
   localparam logic [31:0] SAME_CYCLE_RD2 = 32'hAAAAAAAA;
`else
   localparam logic [31:0] SAME_CYCLE_RD2 = 32'h00000000;
`endif

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   idecode_stage_if #(.PARAM_PC_BITS(PC_BITS)) bus ();

   idecode_stage #(
      .PARAM_NUM_REGS(32),
      .PARAM_PC_BITS (PC_BITS)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct packed {
      logic [8:0]         ctrl;
      logic [31:0]        rd1;
      logic [31:0]        rd2;
      logic [31:0]        sext;
      logic [PC_BITS-1:0] pc;
      logic [4:0]         rt;
      logic [4:0]         rd;
      logic [5:0]         funct;
   } idex_t;

   typedef struct {
      logic [31:0]        instr;
      logic [PC_BITS-1:0] pc;
      logic               flush;
      logic               wb_we;
      logic [4:0]         wb_reg;
      logic [31:0]        wb_data;
      logic               exp_stall;
      idex_t              exp;
   } vec_t;

   int    n_cmp = 0;
   int    n_bad = 0;
   vec_t  vecs[$];
   logic [31:0] mregs [32];

   function automatic idex_t mk(input logic [8:0] c, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic [31:0] sext,
                                input logic [PC_BITS-1:0] pc, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [5:0] fn);
      idex_t s;
      s.ctrl = c; s.rd1 = rd1; s.rd2 = rd2; s.sext = sext;
      s.pc = pc; s.rt = rt; s.rd = rd; s.funct = fn;
      return s;
   endfunction

   function automatic idex_t dut_idex();
      return mk({bus.op_reg_dst, bus.op_alu_src, bus.op_mem_to_reg, bus.op_reg_write,
                 bus.op_mem_read, bus.op_mem_write, bus.op_branch, bus.op_alu_op},
                bus.op_read_data_1, bus.op_read_data_2, bus.op_sign_extend,
                bus.op_PC_plus_4, bus.op_rt, bus.op_rd, bus.op_funct);
   endfunction

   task automatic add_vec(input logic [31:0] instr, input logic [PC_BITS-1:0] pc,
                          input logic flush, input logic wb_we, input logic [4:0] wb_reg,
                          input logic [31:0] wb_data, input logic exp_stall, input idex_t exp);
      vec_t v;
      v.instr = instr; v.pc = pc; v.flush = flush; v.wb_we = wb_we;
      v.wb_reg = wb_reg; v.wb_data = wb_data; v.exp_stall = exp_stall; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [31:0] instr, input logic [PC_BITS-1:0] pc,
                        input logic flush, input logic wb_we, input logic [4:0] wb_reg,
                        input logic [31:0] wb_data);
      bus.ip_instruction   = instr;
      bus.ip_PC_plus_4     = pc;
      bus.ip_flush         = flush;
      bus.ip_wb_reg_write  = wb_we;
      bus.ip_wb_write_reg  = wb_reg;
      bus.ip_wb_write_data = wb_data;
   endtask

   task automatic check_stall(input string name, input logic exp);
      n_cmp++;
      if (bus.op_stall !== exp) begin
         n_bad++;
         $display("FAIL %s stall: got %0b want %0b", name, bus.op_stall, exp);
      end
   endtask

   task automatic check_idex(input string name, input idex_t exp);
      idex_t got;
      got = dut_idex();
      n_cmp++;
      if (got.ctrl !== exp.ctrl) begin
         n_bad++;
         $display("FAIL %s ctrl: got %b want %b", name, got.ctrl, exp.ctrl);
      end
      n_cmp++;
      if ({got.rd1, got.rd2, got.sext, got.pc, got.rt, got.rd, got.funct} !==
          {exp.rd1, exp.rd2, exp.sext, exp.pc, exp.rt, exp.rd, exp.funct}) begin
         n_bad++;
         $display("FAIL %s data: got rd1=%h rd2=%h sext=%h pc=%h rt=%0d rd=%0d fn=%h want rd1=%h rd2=%h sext=%h pc=%h rt=%0d rd=%0d fn=%h",
                  name, got.rd1, got.rd2, got.sext, got.pc, got.rt, got.rd, got.funct,
                  exp.rd1, exp.rd2, exp.sext, exp.pc, exp.rt, exp.rd, exp.funct);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [8:0] model_ctrl(input logic [31:0] ins);
      if (ins == 32'd0) return CTL_NOP;
      case (ins[31:26])
         6'h00:   return CTL_R;
         6'h23:   return CTL_LW;
         6'h2B:   return CTL_SW;
         6'h04:   return CTL_BEQ;
         default: return CTL_NOP;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] r, input logic we,
                                              input logic [4:0] wr, input logic [31:0] wd);
      if (r == 5'd0) return 32'd0;
`ifdef IDECODE_WB_BYPASS_EN
      if (we && wr == r) return wd;
`endif
      return mregs[r];
   endfunction

   function automatic bit model_hazard(input idex_t ex, input logic [31:0] ins);
      bit loads, reads_rt;
      loads    = (ex.ctrl[4] == 1'b1) && (ex.rt != 5'd0);
      reads_rt = ins[31:26] inside {6'h00, 6'h2B, 6'h04};
      return loads && ((ex.rt == ins[25:21]) || (reads_rt && ex.rt == ins[20:16]));
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      ins = $urandom;
      case ($urandom_range(0, 5))
         0:       ins[31:26] = 6'h00;
         1:       ins[31:26] = 6'h23;
         2:       ins[31:26] = 6'h2B;
         3:       ins[31:26] = 6'h04;
         4:       ins[31:26] = 6'($urandom_range(0, 63));
         default: return 32'd0;
      endcase
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
      return ins;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      idex_t             zero;
      idex_t             mex, nxt;
      logic [31:0]       cur;
      logic [PC_BITS-1:0] pc;
      logic              fl, we, prev_stall, exp_stall;
      logic [4:0]        wr;
      logic [31:0]       wd;

      zero = '0;

      // Reset with a live instruction present
      reset = 1'b1;
      drive(32'h8C020000, 10'd4, 1'b0, 1'b1, 5'd2, 32'h12345678);
      @(posedge clock); #1;
      check_stall("reset", 1'b0);
      check_idex("reset", zero);
      drive(32'h0, 10'd0, 1'b0, 1'b0, 5'd0, 32'h0);
      #2 reset = 1'b0;
      @(posedge clock); #1;

      add_vec(32'h00000000, 10'd4,  0, 1, 5'd2, 32'h55555555, 0, mk(CTL_NOP, 0, 0, 0, 10'd4, 0, 0, 0));
      add_vec(32'h00430820, 10'd8,  0, 0, 5'd0, 32'h0, 0, mk(CTL_R, 32'h55555555, 0, 32'h820, 10'd8, 3, 1, 6'h20));
      add_vec(32'h8C020000, 10'd12, 0, 0, 5'd0, 32'h0, 0, mk(CTL_LW, 0, 32'h55555555, 0, 10'd12, 2, 0, 0));
      add_vec(32'h00430820, 10'd16, 0, 0, 5'd0, 32'h0, 1, zero);
      add_vec(32'h00430820, 10'd16, 0, 0, 5'd0, 32'h0, 0, mk(CTL_R, 32'h55555555, 0, 32'h820, 10'd16, 3, 1, 6'h20));
      add_vec(32'h8C000000, 10'd20, 0, 0, 5'd0, 32'h0, 0, mk(CTL_LW, 0, 0, 0, 10'd20, 0, 0, 0));
      add_vec(32'h00000820, 10'd24, 0, 0, 5'd0, 32'h0, 0, mk(CTL_R, 0, 0, 32'h820, 10'd24, 0, 1, 6'h20));
      add_vec(32'h8C020000, 10'd28, 0, 0, 5'd0, 32'h0, 0, mk(CTL_LW, 0, 32'h55555555, 0, 10'd28, 2, 0, 0));
      add_vec(32'h8C030004, 10'd32, 0, 0, 5'd0, 32'h0, 0, mk(CTL_LW, 0, 0, 4, 10'd32, 3, 0, 6'h04));
      add_vec(32'h8C010004, 10'd36, 0, 0, 5'd0, 32'h0, 0, mk(CTL_LW, 0, 0, 4, 10'd36, 1, 0, 6'h04));
      add_vec(32'hAC010008, 10'd40, 1, 0, 5'd0, 32'h0, 0, zero);
      add_vec(32'hAC010008, 10'd40, 0, 0, 5'd0, 32'h0, 0, mk(CTL_SW, 0, 0, 8, 10'd40, 1, 0, 6'h08));
      add_vec(32'h1000FFFA, 10'd44, 0, 0, 5'd0, 32'h0, 0, mk(CTL_BEQ, 0, 0, 32'hFFFFFFFA, 10'd44, 0, 5'd31, 6'h3A));
      add_vec(32'h00000820, 10'd48, 0, 1, 5'd0, 32'hDEADBEEF, 0, mk(CTL_R, 0, 0, 32'h820, 10'd48, 0, 1, 6'h20));
      add_vec(32'h00430820, 10'd52, 0, 1, 5'd3, 32'hAAAAAAAA, 0, mk(CTL_R, 32'h55555555, SAME_CYCLE_RD2, 32'h820, 10'd52, 3, 1, 6'h20));
      add_vec(32'h00000000, 10'd56, 0, 0, 5'd0, 32'h0, 0, mk(CTL_NOP, 0, 0, 0, 10'd56, 0, 0, 0));
      add_vec(32'h00600820, 10'd60, 0, 0, 5'd0, 32'h0, 0, mk(CTL_R, 32'hAAAAAAAA, 0, 32'h820, 10'd60, 0, 1, 6'h20));

      foreach (vecs[i]) begin
         drive(vecs[i].instr, vecs[i].pc, vecs[i].flush, vecs[i].wb_we, vecs[i].wb_reg, vecs[i].wb_data);
         #1;
         check_stall($sformatf("vec%0d", i), vecs[i].exp_stall);
         @(posedge clock); #1;
         check_idex($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Random run from a clean reset; a stalled instruction is held as fetch would
      drive(32'h0, 10'd0, 1'b0, 1'b0, 5'd0, 32'h0);
      reset = 1'b1;
      @(posedge clock); #3 reset = 1'b0;
      @(posedge clock); #1;
      for (int r = 0; r < 32; r++) mregs[r] = 32'd0;
      mex = '0;
      prev_stall = 1'b0;
      cur = 32'd0;
      for (int c = 0; c < 400; c++) begin
         if (!prev_stall) cur = rand_instr();
         pc = PC_BITS'($urandom);
         fl = ($urandom_range(0, 7) == 0);
         we = 1'($urandom_range(0, 1));
         wr = 5'($urandom_range(0, 4));
         wd = $urandom;
         drive(cur, pc, fl, we, wr, wd);
         #1;
         exp_stall = model_hazard(mex, cur) && !fl;
         check_stall("rand", exp_stall);
         if (fl || model_hazard(mex, cur)) begin
            nxt = '0;
         end else begin
            nxt = mk(model_ctrl(cur), model_read(cur[25:21], we, wr, wd),
                     model_read(cur[20:16], we, wr, wd),
                     32'($signed(cur[15:0])), pc, cur[20:16], cur[15:11], cur[5:0]);
         end
         if (we && wr != 5'd0) mregs[wr] = wd;
         @(posedge clock); #1;
         mex = nxt;
         check_idex("rand", mex);
         prev_stall = exp_stall;
      end

      // Reset arriving in the middle of a load-use stall
      drive(32'h8C020000, 10'd100, 1'b0, 1'b1, 5'd2, 32'h55555555);
      @(posedge clock); #1;
      drive(32'h00430820, 10'd104, 1'b0, 1'b0, 5'd0, 32'h0);
      #1;
      check_stall("pre_reset_stall", 1'b1);
      #1 reset = 1'b1;
      #1;
      check_stall("mid_stall_reset", 1'b0);
      check_idex("mid_stall_reset", zero);
      @(posedge clock); #3 reset = 1'b0;
      @(posedge clock); #1;
      drive(32'h00430820, 10'd108, 1'b0, 1'b0, 5'd0, 32'h0);
      #1;
      check_stall("post_reset", 1'b0);
      @(posedge clock); #1;
      check_idex("post_reset_regs_clear", mk(CTL_R, 0, 0, 32'h820, 10'd108, 3, 1, 6'h20));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
